// File: rtl/pio_out_mailbox.sv
// Avalon-MM slave output PIO with a one-deep mailbox, valid/ready toward fabric,
// sticky overflow flag and an accepted-transfer counter.
module pio_out_mailbox #(
  parameter int unsigned DATA_WIDTH  = 10,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_overflow;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [31:0]            r_readdata;
  logic [31:0]            w_rd_mux;
  logic                   w_wr;
  logic                   w_wr_data;
  logic                   w_wr_ctrl;
  logic                   w_accept;
  logic                   w_load;
  logic                   w_ovf_set;
  logic                   w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_wr_data      = w_wr && (address == 2'd0);
  assign w_wr_ctrl      = w_wr && (address == 2'd3);
  assign w_accept       = (r_state == S_FULL) && out_ready;
  assign w_unused_wdata = ^writedata;

  // Mailbox state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_EMPTY;
    else          r_state <= w_state_nxt;
  end

  // A write landing on an accept cycle replaces the consumed value; otherwise a FULL write overflows
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ovf_set   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_wr_data) begin
          w_load      = 1'b1;
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (w_accept) begin
          if (w_wr_data) w_load      = 1'b1;
          else           w_state_nxt = S_EMPTY;
        end else if (w_wr_data) begin
          w_ovf_set = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_data <= '0;
    else if (w_load) r_data <= writedata[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       r_overflow <= 1'b0;
    else if (w_ovf_set)                 r_overflow <= 1'b1;
    else if (w_wr_ctrl && writedata[0]) r_overflow <= 1'b0;
  end

  // Count clear takes priority over a simultaneous accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       r_count <= '0;
    else if (w_wr_ctrl && writedata[1]) r_count <= '0;
    else if (w_accept)                  r_count <= r_count + COUNT_WIDTH'(1);
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (address)
      2'd0:    w_rd_mux = 32'(r_data);
      2'd1:    w_rd_mux = {30'd0, r_overflow, (r_state == S_FULL)};
      2'd2:    w_rd_mux = 32'(r_count);
      default: w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= 32'd0;
    else          r_readdata <= w_rd_mux;
  end

  assign readdata  = r_readdata;
  assign out_port  = r_data;
  assign out_valid = (r_state == S_FULL);

endmodule
